// File: rtl/mem_pkg.sv
// Shared types for the RAM access controller: FSM states, grant encoding and
// the RAM read_write pin levels.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        ST_ADDR = 3'd2,
        ST_PRE  = 3'd3,
        ST_DATA = 3'd4
    } mem_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_LS = 1'b1
    } grant_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational and only issued
// while enabled; the pointer remembers who won the last transfer.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_if,
    input  logic i_req_ls,
    output logic o_gnt_if,
    output logic o_gnt_ls
);

    grant_t r_last_grant;

    always_comb begin
        o_gnt_if = 1'b0;
        o_gnt_ls = 1'b0;
        if (i_en) begin
            if (i_req_if && i_req_ls) begin
                // Contention: the side that did not win last time goes first.
                if (r_last_grant == GRANT_IF) o_gnt_ls = 1'b1;
                else                          o_gnt_if = 1'b1;
            end else begin
                o_gnt_if = i_req_if;
                o_gnt_ls = i_req_ls;
            end
        end
    end

    // A grant is only raised against a valid request, so a grant is a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_last_grant <= GRANT_IF;
        else if (o_gnt_ls) r_last_grant <= GRANT_LS;
        else if (o_gnt_if) r_last_grant <= GRANT_IF;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the single-port RAM: arbitrates fetch vs
// load/store and sequences the RAM pins, including the change-triggered store.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16,
    parameter int WAIT_CYCLES  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDRESS_SIZE-1:0] if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_SIZE-1:0]    if_rsp_instr,
    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic                    ls_req_write,
    input  logic [ADDRESS_SIZE-1:0] ls_addr,
    input  logic [DATA_SIZE-1:0]    ls_wdata,
    output logic                    ls_rsp_valid,
    output logic [DATA_SIZE-1:0]    ls_rsp_rdata,
    output logic                    ram_read_write,
    output logic [ADDRESS_SIZE-1:0] ram_address,
    output logic [DATA_SIZE-1:0]    ram_data_in,
    input  logic [DATA_SIZE-1:0]    ram_data_out,
    input  logic [DATA_SIZE-1:0]    ram_fetch_out,
    output logic                    busy
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    mem_state_t               r_state;
    logic [3:0]               r_cnt;
    logic                     r_is_fetch;
    logic [DATA_SIZE-1:0]     r_wdata;
    logic                     r_rw;
    logic [ADDRESS_SIZE-1:0]  r_address;
    logic [DATA_SIZE-1:0]     r_data_in;
    logic                     r_if_rsp_valid;
    logic [DATA_SIZE-1:0]     r_if_rsp_instr;
    logic                     r_ls_rsp_valid;
    logic [DATA_SIZE-1:0]     r_ls_rsp_rdata;

    logic w_idle;
    logic w_gnt_if;
    logic w_gnt_ls;

    assign w_idle = (r_state == IDLE);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_idle),
        .i_req_if (if_req_valid),
        .i_req_ls (ls_req_valid),
        .o_gnt_if (w_gnt_if),
        .o_gnt_ls (w_gnt_ls)
    );

    assign if_req_ready   = w_gnt_if;
    assign ls_req_ready   = w_gnt_ls;
    assign if_rsp_valid   = r_if_rsp_valid;
    assign if_rsp_instr   = r_if_rsp_instr;
    assign ls_rsp_valid   = r_ls_rsp_valid;
    assign ls_rsp_rdata   = r_ls_rsp_rdata;
    assign ram_read_write = r_rw;
    assign ram_address    = r_address;
    assign ram_data_in    = r_data_in;
    assign busy           = !w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_is_fetch     <= 1'b0;
            r_wdata        <= '0;
            r_rw           <= READ;
            r_address      <= '0;
            r_data_in      <= '0;
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_instr <= '0;
            r_ls_rsp_valid <= 1'b0;
            r_ls_rsp_rdata <= '0;
        end else begin
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_if) begin
                        r_state    <= RD_WAIT;
                        r_is_fetch <= 1'b1;
                        r_address  <= if_addr;
                        r_cnt      <= '0;
                    end else if (w_gnt_ls) begin
                        r_is_fetch <= 1'b0;
                        r_address  <= ls_addr;
                        r_cnt      <= '0;
                        if (ls_req_write) begin
                            r_state <= ST_ADDR;
                            r_rw    <= WRITE;
                            r_wdata <= ls_wdata;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state <= IDLE;
                        if (r_is_fetch) begin
                            r_if_rsp_valid <= 1'b1;
                            r_if_rsp_instr <= ram_fetch_out;
                        end else begin
                            r_ls_rsp_valid <= 1'b1;
                            r_ls_rsp_rdata <= ram_data_out;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                // The RAM only writes when data_in changes, so force two
                // transitions: first to ~wdata, then to wdata.
                ST_ADDR: begin
                    r_state   <= ST_PRE;
                    r_data_in <= ~r_wdata;
                end
                ST_PRE: begin
                    r_state   <= ST_DATA;
                    r_data_in <= r_wdata;
                end
                ST_DATA: begin
                    r_state        <= IDLE;
                    r_rw           <= READ;
                    r_ls_rsp_valid <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_rw    <= READ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural change-triggered RAM, directed table,
// arbitration/reset sequences and randomized traffic against a memory model.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WAIT_CYCLES=1 instance
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [15:0] if_addr;
    logic [31:0] if_rsp_instr;
    logic        ls_req_valid, ls_req_ready, ls_req_write, ls_rsp_valid;
    logic [15:0] ls_addr;
    logic [31:0] ls_wdata, ls_rsp_rdata;
    logic        ram_read_write, busy;
    logic [15:0] ram_address;
    logic [31:0] ram_data_in, ram_data_out, ram_fetch_out;

    // WAIT_CYCLES=3 instance
    logic        d3_if_req_ready, d3_if_rsp_valid;
    logic [31:0] d3_if_rsp_instr;
    logic        d3_ls_req_valid, d3_ls_req_ready, d3_ls_req_write, d3_ls_rsp_valid;
    logic [15:0] d3_ls_addr;
    logic [31:0] d3_ls_wdata, d3_ls_rsp_rdata;
    logic        d3_ram_read_write, d3_busy;
    logic [15:0] d3_ram_address;
    logic [31:0] d3_ram_data_in, d3_ram_data_out, d3_ram_fetch_out;

    mem_access_ctrl #(.DATA_SIZE(32), .ADDRESS_SIZE(16), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_instr(if_rsp_instr),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_write(ls_req_write),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
        .ram_read_write(ram_read_write), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_fetch_out(ram_fetch_out), .busy(busy)
    );

    mem_access_ctrl #(.DATA_SIZE(32), .ADDRESS_SIZE(16), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(1'b0), .if_req_ready(d3_if_req_ready), .if_addr(16'h0),
        .if_rsp_valid(d3_if_rsp_valid), .if_rsp_instr(d3_if_rsp_instr),
        .ls_req_valid(d3_ls_req_valid), .ls_req_ready(d3_ls_req_ready), .ls_req_write(d3_ls_req_write),
        .ls_addr(d3_ls_addr), .ls_wdata(d3_ls_wdata), .ls_rsp_valid(d3_ls_rsp_valid), .ls_rsp_rdata(d3_ls_rsp_rdata),
        .ram_read_write(d3_ram_read_write), .ram_address(d3_ram_address), .ram_data_in(d3_ram_data_in),
        .ram_data_out(d3_ram_data_out), .ram_fetch_out(d3_ram_fetch_out), .busy(d3_busy)
    );

    // RAMs: combinational read of the addressed word, write on a change of data_in.
    logic [31:0] ram1 [0:65535];
    logic [31:0] ram3 [0:65535];
    assign ram_data_out     = ram1[ram_address];
    assign ram_fetch_out    = ram1[ram_address];
    assign d3_ram_data_out  = ram3[d3_ram_address];
    assign d3_ram_fetch_out = ram3[d3_ram_address];
    always @(ram_data_in)    if (ram_read_write == 1'b0)    ram1[ram_address]    = ram_data_in;
    always @(d3_ram_data_in) if (d3_ram_read_write == 1'b0) ram3[d3_ram_address] = d3_ram_data_in;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] mdl [logic [15:0]];
    logic [31:0] last_ld;

    typedef struct {
        bit          is_if;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] mget(input logic [15:0] a);
        return mdl.exists(a) ? mdl[a] : 32'h0;
    endfunction

    // One transaction on the WAIT_CYCLES=1 instance; lat counts negedges after the accept edge.
    task automatic xfer(input bit is_if, input bit wr, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
        int n;
        if (is_if) begin if_req_valid = 1'b1; if_addr = a; end
        else begin ls_req_valid = 1'b1; ls_req_write = wr; ls_addr = a; ls_wdata = d; end
        #1;
        n = 0;
        while (!(is_if ? if_req_ready : ls_req_ready) && n < 50) begin @(negedge clk); #1; n++; end
        if (n == 50) begin
            n_chk++;
            $display("FAIL accept_timeout: got no ready expected ready");
        end
        @(posedge clk);
        @(negedge clk);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        lat = 1;
        #1;
        while (!(is_if ? if_rsp_valid : ls_rsp_valid) && lat < 40) begin @(negedge clk); #1; lat++; end
        rd = is_if ? if_rsp_instr : ls_rsp_rdata;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rw"},      32'(ram_read_write), 32'h1);
        chk({tag, "_addr"},    32'(ram_address),    32'h0);
        chk({tag, "_din"},     ram_data_in,          32'h0);
        chk({tag, "_busy"},    32'(busy),            32'h0);
        chk({tag, "_ifv"},     32'(if_rsp_valid),    32'h0);
        chk({tag, "_lsv"},     32'(ls_rsp_valid),    32'h0);
        chk({tag, "_instr"},   if_rsp_instr,         32'h0);
        chk({tag, "_rdata"},   ls_rsp_rdata,         32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, grants, nif, nls, nrsp;
        bit exp_ls;

        rst_n = 1'b0;
        if_req_valid = 0; if_addr = 0;
        ls_req_valid = 0; ls_req_write = 0; ls_addr = 0; ls_wdata = 0;
        d3_ls_req_valid = 0; d3_ls_req_write = 0; d3_ls_addr = 0; d3_ls_wdata = 0;

        tbl[0] = '{0, 1, 16'h0004, 32'hDEADBEEF, 32'h0,        4};
        tbl[1] = '{1, 0, 16'h0004, 32'h0,        32'hDEADBEEF, 2};
        tbl[2] = '{0, 1, 16'h0010, 32'h12345678, 32'h0,        4};
        tbl[3] = '{0, 0, 16'h0010, 32'h0,        32'h12345678, 2};
        tbl[4] = '{0, 1, 16'h0010, 32'h12345678, 32'h12345678, 4};
        tbl[5] = '{0, 0, 16'h0010, 32'h0,        32'h12345678, 2};
        tbl[6] = '{0, 1, 16'h0011, 32'h0,        32'h12345678, 4};
        tbl[7] = '{0, 0, 16'h0011, 32'h0,        32'h0,        2};
        tbl[8] = '{1, 0, 16'h0010, 32'h0,        32'h12345678, 2};
        tbl[9] = '{0, 0, 16'h0004, 32'h0,        32'hDEADBEEF, 2};

        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // WAIT_CYCLES=3: store then load, checking latency and busy per cycle.
        d3_ls_req_valid = 1; d3_ls_req_write = 1; d3_ls_addr = 16'h0020; d3_ls_wdata = 32'hCAFEF00D;
        #1;
        chk("w3_st_ready", 32'(d3_ls_req_ready), 32'h1);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            d3_ls_req_valid = 0;
            #1;
            if (k == 4) chk("w3_st_rsp", 32'(d3_ls_rsp_valid), 32'h1);
        end
        d3_ls_req_valid = 1; d3_ls_req_write = 0;
        #1;
        chk("w3_ld_ready", 32'(d3_ls_req_ready), 32'h1);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            d3_ls_req_valid = 0;
            #1;
            if (k <= 3) begin
                chk($sformatf("w3_busy%0d", k), 32'(d3_busy), 32'h1);
                chk($sformatf("w3_norsp%0d", k), 32'(d3_ls_rsp_valid), 32'h0);
            end else begin
                chk("w3_rsp", 32'(d3_ls_rsp_valid), 32'h1);
                chk("w3_data", d3_ls_rsp_rdata, 32'hCAFEF00D);
                chk("w3_idle", 32'(d3_busy), 32'h0);
            end
        end

        // Directed table on the WAIT_CYCLES=1 instance.
        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i].is_if, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, lat);
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            if (tbl[i].wr) mdl[tbl[i].addr] = tbl[i].wdata;
        end

        // Round-robin: both requesters valid continuously, six grants.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst1");
        @(negedge clk);
        rst_n = 1'b1;
        if_req_valid = 1; if_addr = 16'h0004;
        ls_req_valid = 1; ls_req_write = 0; ls_addr = 16'h0010;
        grants = 0; nif = 0; nls = 0; exp_ls = 1;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (if_rsp_valid) begin nif++; chk("rr_if_data", if_rsp_instr, mget(16'h0004)); end
            if (ls_rsp_valid) begin nls++; chk("rr_ls_data", ls_rsp_rdata, mget(16'h0010)); end
            if (grants == 6) begin
                if_req_valid = 0;
                ls_req_valid = 0;
            end else if (if_req_ready || ls_req_ready) begin
                chk($sformatf("rr_order%0d", grants), 32'(ls_req_ready), 32'(exp_ls));
                chk("rr_onehot", 32'(if_req_ready & ls_req_ready), 32'h0);
                exp_ls = !exp_ls;
                grants++;
            end
            @(negedge clk);
            #1;
        end
        chk("rr_grants", 32'(grants), 32'd6);
        chk("rr_nif", 32'(nif), 32'd3);
        chk("rr_nls", 32'(nls), 32'd3);

        // Reset while the store sits in ST_PRE.
        ls_req_valid = 1; ls_req_write = 1; ls_addr = 16'h0030; ls_wdata = 32'hA5A5A5A5;
        #1;
        chk("pre_ready", 32'(ls_req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        ls_req_valid = 0;
        @(negedge clk);
        #1;
        chk("pre_rw", 32'(ram_read_write), 32'h0);
        chk("pre_din", ram_data_in, 32'h5A5A5A5A);
        chk("pre_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        ls_req_valid = 1; ls_req_write = 0; ls_addr = 16'h0;
        #1;
        chk("post_rst_ready", 32'(ls_req_ready), 32'h1);
        ls_req_valid = 0;
        nrsp = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (ls_rsp_valid || if_rsp_valid) nrsp++;
        end
        chk("post_rst_norsp", 32'(nrsp), 32'h0);
        xfer(0, 1, 16'h0030, 32'hA5A5A5A5, rd, lat);
        chk("reissue_lat", 32'(lat), 32'd4);
        mdl[16'h0030] = 32'hA5A5A5A5;
        xfer(0, 0, 16'h0030, 32'h0, rd, lat);
        chk("reissue_data", rd, 32'hA5A5A5A5);
        last_ld = 32'hA5A5A5A5;

        // Randomized traffic against the memory model.
        for (int a = 0; a < 8; a++) begin
            logic [31:0] d;
            d = $urandom;
            xfer(0, 1, 16'(16'h0040 + a), d, rd, lat);
            mdl[16'(16'h0040 + a)] = d;
            chk("rnd_init_lat", 32'(lat), 32'd4);
        end
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [15:0] a;
            logic [31:0] d;
            kind = int'($urandom_range(0, 2));
            a = 16'(16'h0040 + $urandom_range(0, 7));
            d = $urandom;
            if (kind == 0) begin
                xfer(1, 0, a, 32'h0, rd, lat);
                chk($sformatf("rnd%0d_fetch", i), rd, mget(a));
                chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd2);
            end else if (kind == 1) begin
                xfer(0, 0, a, 32'h0, rd, lat);
                chk($sformatf("rnd%0d_load", i), rd, mget(a));
                chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd2);
                last_ld = mget(a);
            end else begin
                xfer(0, 1, a, d, rd, lat);
                chk($sformatf("rnd%0d_hold", i), rd, last_ld);
                chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd4);
                mdl[a] = d;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
